// File: rtl/pc_sequencer.sv
// pc_sequencer: program-counter and phase sequencer for a single-cycle datapath.
// Each instruction runs FETCH (clkA), EXEC_CYCLES of EXEC, WB (clkB), then UPDATE.
// UPDATE latches the datapath's next PC and counts the instruction as retired.
// The block also handles run/step/halt control and a HALT instruction word.
// Optional breakpoint unit: define PC_SEQ_BREAKPOINT_EN.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          EXEC_CYCLES = 2,
    parameter logic [31:0] HALT_INSTR  = 32'hFFFF_FFFF,
    parameter int          CNT_W       = 32
) (
    input  logic             fast_clk,
    input  logic             rst,
    input  logic             run,
    input  logic             step,
    input  logic             resume,
    input  logic             halt_req,
    input  logic [31:0]      next_pc,
    input  logic [31:0]      instr,
`ifdef PC_SEQ_BREAKPOINT_EN
    input  logic [31:0]      bp_addr,
    input  logic             bp_en,
    output logic             bp_hit,
`endif
    output logic [31:0]      pc,
    output logic             clkA,
    output logic             clkB,
    output logic             halted,
    output logic             busy,
    output logic             misalign,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_EXEC, S_WB, S_UPDATE, S_HALTED
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic [3:0]       cnt_q, cnt_d;
    logic             single_q, single_d;
    logic             hpend_q, hpend_d;
    logic             hinstr_q, hinstr_d;   // HALTED was entered via HALT_INSTR
    logic             misalign_q, misalign_d;
    logic [CNT_W-1:0] icnt_q, icnt_d;
    logic             clka_q, clka_d;
    logic             clkb_q, clkb_d;
    logic             halted_q, halted_d;
    logic             busy_q, busy_d;
    logic             fetch_req;
    logic             in_busy;
`ifdef PC_SEQ_BREAKPOINT_EN
    logic             bp_hit_q, bp_hit_d;
    logic             bp_skip_q, bp_skip_d; // let the instruction at bp_addr run once after resume
`endif

    // Next-state, PC, counter and flag computation; outputs decoded from next state
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        cnt_d      = cnt_q;
        single_d   = single_q;
        hpend_d    = hpend_q;
        hinstr_d   = hinstr_q;
        misalign_d = misalign_q;
        icnt_d     = icnt_q;
        fetch_req  = 1'b0;
`ifdef PC_SEQ_BREAKPOINT_EN
        bp_hit_d   = bp_hit_q;
        bp_skip_d  = bp_skip_q;
`endif
        in_busy = (state_q == S_FETCH) || (state_q == S_EXEC) ||
                  (state_q == S_WB)    || (state_q == S_UPDATE);
        if (in_busy && halt_req)
            hpend_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (run) begin
                    fetch_req = 1'b1;
                end else if (step) begin
                    fetch_req = 1'b1;
                    single_d  = 1'b1;
                end
            end
            S_FETCH: begin
                state_d = S_EXEC;
                cnt_d   = 4'(EXEC_CYCLES - 1);
            end
            S_EXEC: begin
                if (cnt_q == 4'd0) begin
                    if (instr == HALT_INSTR) begin
                        state_d  = S_HALTED;
                        hinstr_d = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_WB: state_d = S_UPDATE;
            S_UPDATE: begin
                pc_d       = {next_pc[31:2], 2'b00};
                icnt_d     = icnt_q + CNT_W'(1);
                misalign_d = misalign_q | (next_pc[1:0] != 2'b00);
                if (hpend_q || halt_req) begin
                    state_d = S_HALTED;
                end else if (single_q || !run) begin
                    state_d  = S_IDLE;
                    single_d = 1'b0;
                end else begin
                    fetch_req = 1'b1;
                end
            end
            S_HALTED: begin
                if (resume) begin
                    state_d  = S_IDLE;
                    hinstr_d = 1'b0;
                    if (hinstr_q)
                        pc_d = pc_q + 32'd4;
`ifdef PC_SEQ_BREAKPOINT_EN
                    if (bp_hit_q) begin
                        bp_hit_d  = 1'b0;
                        bp_skip_d = 1'b1;
                    end
`endif
                end
            end
            default: state_d = S_IDLE;
        endcase

        // FETCH entry, compared against the PC this fetch would use
        if (fetch_req) begin
`ifdef PC_SEQ_BREAKPOINT_EN
            if (bp_en && (pc_d == bp_addr) && !bp_skip_q) begin
                state_d  = S_HALTED;
                bp_hit_d = 1'b1;
            end else begin
                state_d   = S_FETCH;
                bp_skip_d = 1'b0;
            end
`else
            state_d = S_FETCH;
`endif
        end

        // Entering HALTED drops any queued halt and the single-step flag
        if ((state_d == S_HALTED) && (state_q != S_HALTED)) begin
            hpend_d  = 1'b0;
            single_d = 1'b0;
        end

        clka_d   = (state_d == S_FETCH);
        clkb_d   = (state_d == S_WB);
        halted_d = (state_d == S_HALTED);
        busy_d   = (state_d == S_FETCH) || (state_d == S_EXEC) ||
                   (state_d == S_WB)    || (state_d == S_UPDATE);
    end

    // State and registered outputs; reset aborts any instruction in flight
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            cnt_q      <= 4'd0;
            single_q   <= 1'b0;
            hpend_q    <= 1'b0;
            hinstr_q   <= 1'b0;
            misalign_q <= 1'b0;
            icnt_q     <= '0;
            clka_q     <= 1'b0;
            clkb_q     <= 1'b0;
            halted_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            cnt_q      <= cnt_d;
            single_q   <= single_d;
            hpend_q    <= hpend_d;
            hinstr_q   <= hinstr_d;
            misalign_q <= misalign_d;
            icnt_q     <= icnt_d;
            clka_q     <= clka_d;
            clkb_q     <= clkb_d;
            halted_q   <= halted_d;
            busy_q     <= busy_d;
        end
    end

`ifdef PC_SEQ_BREAKPOINT_EN
    // Breakpoint flags
    always_ff @(posedge fast_clk or posedge rst) begin
        if (rst) begin
            bp_hit_q  <= 1'b0;
            bp_skip_q <= 1'b0;
        end else begin
            bp_hit_q  <= bp_hit_d;
            bp_skip_q <= bp_skip_d;
        end
    end

    assign bp_hit = bp_hit_q;
`endif

    assign pc          = pc_q;
    assign clkA        = clka_q;
    assign clkB        = clkb_q;
    assign halted      = halted_q;
    assign busy        = busy_q;
    assign misalign    = misalign_q;
    assign instr_count = icnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a cycle table for free-run mode plus
// hand-written step / halt / misalign / reset (and breakpoint) sequences.
module tb_pc_sequencer;

    logic        fast_clk = 1'b0;
    logic        rst, run, step, resume, halt_req;
    logic [31:0] next_pc, instr;
    logic [31:0] pc;
    logic        clkA, clkB, halted, busy, misalign;
    logic [31:0] instr_count;
`ifdef PC_SEQ_BREAKPOINT_EN
    logic [31:0] bp_addr;
    logic        bp_en, bp_hit;
`endif

    // datapath stand-in: either sequential next PC or a fixed value
    logic        np_auto;
    logic [31:0] np_val;
    assign next_pc = np_auto ? pc + 32'd4 : np_val;

    int total = 0;
    int bad   = 0;
    int na, nb;

    pc_sequencer dut (
        .fast_clk    (fast_clk),
        .rst         (rst),
        .run         (run),
        .step        (step),
        .resume      (resume),
        .halt_req    (halt_req),
        .next_pc     (next_pc),
        .instr       (instr),
`ifdef PC_SEQ_BREAKPOINT_EN
        .bp_addr     (bp_addr),
        .bp_en       (bp_en),
        .bp_hit      (bp_hit),
`endif
        .pc          (pc),
        .clkA        (clkA),
        .clkB        (clkB),
        .halted      (halted),
        .busy        (busy),
        .misalign    (misalign),
        .instr_count (instr_count)
    );

    always #5 fast_clk = ~fast_clk;

    typedef struct packed {
        logic        run;
        logic        ca;
        logic        cb;
        logic        bz;
        logic [31:0] pc;
        logic [31:0] cnt;
    } vec_t;

    vec_t tbl [16];

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // one pulse of step, then n more cycles while counting strobes
    task automatic step_and_count(input int n);
        step = 1'b1;
        tick();
        step = 1'b0;
        na = int'(clkA);
        nb = int'(clkB);
        repeat (n) begin
            tick();
            na += int'(clkA);
            nb += int'(clkB);
        end
    endtask

    initial begin
        // cycle k = state after the k-th edge following reset release
        tbl[0]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'd0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'd0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'd0};
        tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h0, 32'd0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'd0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h4, 32'd1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 32'd1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 32'd1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h4, 32'd1};
        tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h4, 32'd1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h8, 32'd2};
        tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'd2};
        tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'd2};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 32'd2};
        tbl[14] = '{1'b1, 1'b0, 1'b0, 1'b1, 32'h8, 32'd2};
        tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'hC, 32'd3};

        rst = 1'b1; run = 1'b0; step = 1'b0; resume = 1'b0; halt_req = 1'b0;
        instr = 32'h0; np_auto = 1'b1; np_val = 32'h0;
`ifdef PC_SEQ_BREAKPOINT_EN
        bp_addr = 32'h0; bp_en = 1'b0;
`endif
        tick();
        tick();
        chk("rst_pc", pc, 32'h0);
        chk("rst_clkA", {31'b0, clkA}, 32'h0);
        chk("rst_clkB", {31'b0, clkB}, 32'h0);
        chk("rst_halted", {31'b0, halted}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_misalign", {31'b0, misalign}, 32'h0);
        chk("rst_count", instr_count, 32'h0);
        rst = 1'b0;

        // free-run: three back-to-back instructions, then pause
        for (int i = 0; i < 16; i++) begin
            run = tbl[i].run;
            tick();
            chk($sformatf("run_c%0d_clkA", i + 1), {31'b0, clkA}, {31'b0, tbl[i].ca});
            chk($sformatf("run_c%0d_clkB", i + 1), {31'b0, clkB}, {31'b0, tbl[i].cb});
            chk($sformatf("run_c%0d_busy", i + 1), {31'b0, busy}, {31'b0, tbl[i].bz});
            chk($sformatf("run_c%0d_pc", i + 1), pc, tbl[i].pc);
            chk($sformatf("run_c%0d_cnt", i + 1), instr_count, tbl[i].cnt);
        end

        // single step to a fixed target
        np_auto = 1'b0; np_val = 32'h40;
        step_and_count(7);
        chk("step_clkA_n", 32'(na), 32'd1);
        chk("step_clkB_n", 32'(nb), 32'd1);
        chk("step_pc", pc, 32'h40);
        chk("step_cnt", instr_count, 32'd4);
        chk("step_busy", {31'b0, busy}, 32'h0);
        chk("step_halted", {31'b0, halted}, 32'h0);

        // HALT instruction at 0x10: no writeback, resume skips it
        np_val = 32'h10;
        step_and_count(7);
        chk("hi_setup_pc", pc, 32'h10);
        instr = 32'hFFFF_FFFF;
        step_and_count(8);
        chk("hi_clkB_n", 32'(nb), 32'd0);
        chk("hi_halted", {31'b0, halted}, 32'h1);
        chk("hi_pc", pc, 32'h10);
        chk("hi_cnt", instr_count, 32'd5);
        chk("hi_busy", {31'b0, busy}, 32'h0);
        step_and_count(3);
        chk("hi_step_ignored", {31'b0, halted}, 32'h1);
        instr = 32'h0;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("hi_res_halted", {31'b0, halted}, 32'h0);
        chk("hi_res_pc", pc, 32'h14);
        chk("hi_res_busy", {31'b0, busy}, 32'h0);

        // halt_req during EXEC: instruction retires, then halts
        np_val = 32'h20;
        step = 1'b1;
        tick();
        step = 1'b0;
        tick();
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        repeat (5) tick();
        chk("hr_halted", {31'b0, halted}, 32'h1);
        chk("hr_pc", pc, 32'h20);
        chk("hr_cnt", instr_count, 32'd6);
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("hr_res_halted", {31'b0, halted}, 32'h0);
        chk("hr_res_pc", pc, 32'h20);
        chk("hr_res_busy", {31'b0, busy}, 32'h0);

        // misaligned target is truncated and sticks
        np_val = 32'h23;
        step_and_count(7);
        chk("ma_pc", pc, 32'h20);
        chk("ma_flag", {31'b0, misalign}, 32'h1);
        chk("ma_cnt", instr_count, 32'd7);
        np_val = 32'h24;
        step_and_count(7);
        chk("ma_pc2", pc, 32'h24);
        chk("ma_sticky", {31'b0, misalign}, 32'h1);
        chk("ma_cnt2", instr_count, 32'd8);

        // reset in the middle of WB
        np_auto = 1'b1;
        run = 1'b1;
        repeat (4) tick();
        chk("rw_in_wb", {31'b0, clkB}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rw_clkB", {31'b0, clkB}, 32'h0);
        chk("rw_pc", pc, 32'h0);
        chk("rw_cnt", instr_count, 32'h0);
        chk("rw_busy", {31'b0, busy}, 32'h0);
        chk("rw_misalign", {31'b0, misalign}, 32'h0);
        run = 1'b0;
        #2;
        rst = 1'b0;
        tick();
        chk("rw_idle", {31'b0, busy}, 32'h0);

`ifdef PC_SEQ_BREAKPOINT_EN
        // breakpoint at 8: 0 and 4 retire, then halt before fetching 8
        bp_addr = 32'h8; bp_en = 1'b1;
        run = 1'b1;
        na = 0;
        repeat (12) begin
            tick();
            na += int'(clkA);
        end
        chk("bp_clkA_n", 32'(na), 32'd2);
        chk("bp_halted", {31'b0, halted}, 32'h1);
        chk("bp_pc", pc, 32'h8);
        chk("bp_hit", {31'b0, bp_hit}, 32'h1);
        chk("bp_cnt", instr_count, 32'd2);
        run = 1'b0;
        resume = 1'b1;
        tick();
        resume = 1'b0;
        chk("bp_res_hit", {31'b0, bp_hit}, 32'h0);
        chk("bp_res_halted", {31'b0, halted}, 32'h0);
        step_and_count(7);
        chk("bp_skip_clkA_n", 32'(na), 32'd1);
        chk("bp_skip_pc", pc, 32'hC);
        chk("bp_skip_cnt", instr_count, 32'd3);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
